// File: rtl/op_dispatcher.sv
// op_dispatcher: registered, flow-controlled monitor-link op decoder.
// Decodes 16-bit packets into one-cycle command pulses, tracks the audio
// stream state (IDLE/RUN22/RUN44) with an idle timeout, and forwards
// sample payloads through a one-entry valid/ready output buffer.
// Ports: clk, reset (sync, active-high); op/op_valid/op_ready packet in;
// power_on_r1, kbd_led_update, all_1_packet, audio_start, orphan_sample,
// stream_timeout pulses; audio_active, audio_rate_44k stream state;
// sample_data/sample_valid/sample_ready sample out; sample_count.
// Optional (OPDISP_ERR_STATS_EN): unknown_op_count, err_sticky.
module op_dispatcher #(
  parameter int OP_WIDTH = 16,
  parameter int SAMPLE_W = OP_WIDTH - 8,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_WIDTH-1:0] op,
  input  logic                op_valid,
  output logic                op_ready,
  output logic                power_on_r1,
  output logic                kbd_led_update,
  output logic                all_1_packet,
  output logic                audio_start,
  output logic                audio_active,
  output logic                audio_rate_44k,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [CNT_W-1:0]    sample_count,
  output logic                orphan_sample,
  output logic                stream_timeout
`ifdef OPDISP_ERR_STATS_EN
  ,
  output logic [15:0]         unknown_op_count,
  output logic                err_sticky
`endif
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [OP_WIDTH-1:0] OP_PWR =
    {8'hc5, (OP_WIDTH-8)'(8'hef)};
  localparam logic [OP_WIDTH-1:0] OP_LED =
    {8'hc5, (OP_WIDTH-8)'(8'h00)};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN22,
    S_RUN44
  } state_e;

  typedef enum logic [2:0] {
    K_NONE,
    K_PWR,
    K_LED,
    K_ALL1,
    K_S22,
    K_S44,
    K_SMP,
    K_UNK
  } kind_e;

  state_e               state_q, state_d;
  logic                 pwr_q, pwr_d;
  logic                 led_q, led_d;
  logic                 all1_q, all1_d;
  logic                 start_q, start_d;
  logic                 orphan_q, orphan_d;
  logic                 tmo_pulse_q, tmo_pulse_d;
  logic                 sv_q, sv_d;
  logic [SAMPLE_W-1:0]  sd_q, sd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;

  logic [7:0]           cmd;
  logic [SAMPLE_W-1:0]  payload;
  logic                 op_acc;
  logic                 running;
  kind_e                kind;

  assign cmd     = op[OP_WIDTH-1 -: 8];
  assign payload = SAMPLE_W'(op[OP_WIDTH-9:0]);

  // Backpressure depends only on the buffer, so packets of every kind
  // stall together and command order is preserved.
  assign op_ready = !sv_q || sample_ready;
  assign op_acc   = op_valid && op_ready;
  assign running  = (state_q != S_IDLE);

  always_comb begin
    kind = K_NONE;
    if (op_acc) begin
      unique case (1'b1)
        (op == OP_PWR): kind = K_PWR;
        (op == OP_LED): kind = K_LED;
        (cmd == 8'hff): kind = K_ALL1;
        (cmd == 8'h1f): kind = K_S22;
        (cmd == 8'h0f): kind = K_S44;
        (cmd == 8'hc7): kind = K_SMP;
        default:        kind = K_UNK;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    pwr_d       = 1'b0;
    led_d       = 1'b0;
    all1_d      = 1'b0;
    start_d     = 1'b0;
    orphan_d    = 1'b0;
    tmo_pulse_d = 1'b0;
    sv_d        = sv_q;
    sd_d        = sd_q;
    cnt_d       = cnt_q;
    tmo_cnt_d   = '0;

    if (sv_q && sample_ready) begin
      sv_d = 1'b0;
    end

    // Idle timer; any packet below that touches the stream overrides it.
    if (running && (TIMEOUT != 0)) begin
      if (tmo_cnt_q == TMO_LAST) begin
        state_d     = S_IDLE;
        tmo_pulse_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end

    case (kind)
      K_PWR: pwr_d = 1'b1;
      K_LED: led_d = 1'b1;
      K_ALL1: begin
        all1_d      = 1'b1;
        state_d     = S_IDLE;
        sv_d        = 1'b0;
        tmo_pulse_d = 1'b0;
        tmo_cnt_d   = '0;
      end
      K_S22, K_S44: begin
        start_d     = 1'b1;
        state_d     = (kind == K_S44) ? S_RUN44 : S_RUN22;
        cnt_d       = '0;
        tmo_pulse_d = 1'b0;
        tmo_cnt_d   = '0;
      end
      K_SMP: begin
        if (running) begin
          sd_d        = payload;
          sv_d        = 1'b1;
          state_d     = state_q;
          tmo_pulse_d = 1'b0;
          tmo_cnt_d   = '0;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          orphan_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pwr_q       <= 1'b0;
      led_q       <= 1'b0;
      all1_q      <= 1'b0;
      start_q     <= 1'b0;
      orphan_q    <= 1'b0;
      tmo_pulse_q <= 1'b0;
      sv_q        <= 1'b0;
      sd_q        <= '0;
      cnt_q       <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pwr_q       <= pwr_d;
      led_q       <= led_d;
      all1_q      <= all1_d;
      start_q     <= start_d;
      orphan_q    <= orphan_d;
      tmo_pulse_q <= tmo_pulse_d;
      sv_q        <= sv_d;
      sd_q        <= sd_d;
      cnt_q       <= cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign power_on_r1    = pwr_q;
  assign kbd_led_update = led_q;
  assign all_1_packet   = all1_q;
  assign audio_start    = start_q;
  assign orphan_sample  = orphan_q;
  assign stream_timeout = tmo_pulse_q;
  assign audio_active   = running;
  assign audio_rate_44k = (state_q == S_RUN44);
  assign sample_data    = sd_q;
  assign sample_valid   = sv_q;
  assign sample_count   = cnt_q;

`ifdef OPDISP_ERR_STATS_EN
  logic [15:0] unk_cnt_q, unk_cnt_d;
  logic        err_q, err_d;
  logic        unk;

  assign unk = (kind == K_UNK);

  always_comb begin
    unk_cnt_d = unk_cnt_q;
    if (unk && (unk_cnt_q != 16'hffff)) begin
      unk_cnt_d = unk_cnt_q + 16'd1;
    end
    err_d = err_q | orphan_d | tmo_pulse_d | unk;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      unk_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      unk_cnt_q <= unk_cnt_d;
      err_q     <= err_d;
    end
  end

  assign unknown_op_count = unk_cnt_q;
  assign err_sticky       = err_q;
`endif

endmodule

// File: tb/tb_op_dispatcher.sv
// tb_op_dispatcher: table-driven cycle vectors for op_dispatcher with a
// sample scoreboard; plus reset-mid-stream and end-of-run checks.
module tb_op_dispatcher;

  logic        clk;
  logic        reset;
  logic [15:0] op;
  logic        op_valid;
  logic        op_ready;
  logic        power_on_r1;
  logic        kbd_led_update;
  logic        all_1_packet;
  logic        audio_start;
  logic        audio_active;
  logic        audio_rate_44k;
  logic [7:0]  sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] sample_count;
  logic        orphan_sample;
  logic        stream_timeout;
`ifdef OPDISP_ERR_STATS_EN
  logic [15:0] unknown_op_count;
  logic        err_sticky;
`endif

  op_dispatcher #(
    .OP_WIDTH(16),
    .SAMPLE_W(8),
    .CNT_W(16),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .op(op),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .power_on_r1(power_on_r1),
    .kbd_led_update(kbd_led_update),
    .all_1_packet(all_1_packet),
    .audio_start(audio_start),
    .audio_active(audio_active),
    .audio_rate_44k(audio_rate_44k),
    .sample_data(sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_count(sample_count),
    .orphan_sample(orphan_sample),
    .stream_timeout(stream_timeout)
`ifdef OPDISP_ERR_STATS_EN
    ,
    .unknown_op_count(unknown_op_count),
    .err_sticky(err_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] P_PW  = 6'b100000;
  localparam logic [5:0] P_LED = 6'b010000;
  localparam logic [5:0] P_FF  = 6'b001000;
  localparam logic [5:0] P_ST  = 6'b000100;
  localparam logic [5:0] P_OR  = 6'b000010;
  localparam logic [5:0] P_TO  = 6'b000001;

  typedef struct {
    logic [15:0] op;
    logic        v;
    logic        r;
    logic        rdy;
    logic [5:0]  pls;
    logic        act;
    logic        r44;
    logic        sv;
    logic [7:0]  sd;
    logic [15:0] cnt;
    logic        p;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb[$];
  int         n_vec = 0;
  int         n_err = 0;

  logic [5:0] pls;
  assign pls = {power_on_r1, kbd_led_update, all_1_packet,
                audio_start, orphan_sample, stream_timeout};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] o, input logic v,
                     input logic r, input logic rdy,
                     input logic [5:0] p6, input logic act,
                     input logic r44, input logic sv,
                     input logic [7:0] sd, input logic [15:0] cnt,
                     input logic p);
    vec_t t;
    t.op = o; t.v = v; t.r = r; t.rdy = rdy; t.pls = p6;
    t.act = act; t.r44 = r44; t.sv = sv; t.sd = sd;
    t.cnt = cnt; t.p = p;
    tbl.push_back(t);
  endtask

  task automatic run(input int i, input vec_t t);
    op = t.op;
    op_valid = t.v;
    sample_ready = t.r;
    if (t.p) sb.push_back(t.op[7:0]);
    @(negedge clk);
    chk($sformatf("s%0d_op_ready", i), op_ready, t.rdy);
    @(posedge clk);
    #1;
    chk($sformatf("s%0d_pulses", i), pls, t.pls);
    chk($sformatf("s%0d_active", i), audio_active, t.act);
    chk($sformatf("s%0d_rate44", i), audio_rate_44k, t.r44);
    chk($sformatf("s%0d_svalid", i), sample_valid, t.sv);
    if (t.sv) chk($sformatf("s%0d_sdata", i), sample_data, t.sd);
    chk($sformatf("s%0d_count", i), sample_count, t.cnt);
  endtask

  // Every completed sample handshake must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && sample_valid && sample_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_pop: unexpected sample %0h", sample_data);
      end else begin
        chk("sb_sample", sample_data, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    op = '0;
    op_valid = 1'b0;
    sample_ready = 1'b0;

    add(16'hc5ef, 1, 0, 1, P_PW,  0, 0, 0, 8'h00, 0, 0);
    add(16'h0000, 0, 0, 1, 6'd0,  0, 0, 0, 8'h00, 0, 0);
    add(16'hc500, 1, 0, 1, P_LED, 0, 0, 0, 8'h00, 0, 0);
    add(16'h1f00, 1, 1, 1, P_ST,  1, 0, 0, 8'h00, 0, 0);
    add(16'hc712, 1, 1, 1, 6'd0,  1, 0, 1, 8'h12, 1, 1);
    add(16'hc734, 1, 1, 1, 6'd0,  1, 0, 1, 8'h34, 2, 1);
    add(16'hc756, 1, 1, 1, 6'd0,  1, 0, 1, 8'h56, 3, 1);
    add(16'hc5ef, 1, 1, 1, P_PW,  1, 0, 0, 8'h00, 3, 0);
    add(16'h0f00, 1, 0, 1, P_ST,  1, 1, 0, 8'h00, 0, 0);
    add(16'hc7aa, 1, 0, 1, 6'd0,  1, 1, 1, 8'haa, 1, 1);
    add(16'hc7bb, 1, 0, 0, 6'd0,  1, 1, 1, 8'haa, 1, 0);
    add(16'hc7bb, 1, 0, 0, 6'd0,  1, 1, 1, 8'haa, 1, 0);
    add(16'hc7bb, 1, 1, 1, 6'd0,  1, 1, 1, 8'hbb, 2, 1);
    add(16'h0000, 0, 1, 1, 6'd0,  1, 1, 0, 8'h00, 2, 0);
    add(16'h1f00, 1, 0, 1, P_ST,  1, 0, 0, 8'h00, 0, 0);
    add(16'hc7cc, 1, 0, 1, 6'd0,  1, 0, 1, 8'hcc, 1, 1);
    add(16'h0000, 0, 0, 0, 6'd0,  1, 0, 1, 8'hcc, 1, 0);
    add(16'hffff, 1, 1, 1, P_FF,  0, 0, 0, 8'h00, 1, 0);
    add(16'hc7ff, 1, 0, 1, P_OR,  0, 0, 0, 8'h00, 1, 0);
    add(16'h0000, 0, 0, 1, 6'd0,  0, 0, 0, 8'h00, 1, 0);
    add(16'h1234, 1, 0, 1, 6'd0,  0, 0, 0, 8'h00, 1, 0);
    add(16'hff00, 1, 0, 1, P_FF,  0, 0, 0, 8'h00, 1, 0);
    add(16'h0f00, 1, 0, 1, P_ST,  1, 1, 0, 8'h00, 0, 0);
    for (int k = 0; k < 7; k++)
      add(16'h0000, 0, 0, 1, 6'd0, 1, 1, 0, 8'h00, 0, 0);
    add(16'h0000, 0, 0, 1, P_TO,  0, 0, 0, 8'h00, 0, 0);
    add(16'h0000, 0, 0, 1, 6'd0,  0, 0, 0, 8'h00, 0, 0);
    add(16'h1f00, 1, 0, 1, P_ST,  1, 0, 0, 8'h00, 0, 0);
    for (int k = 0; k < 7; k++)
      add(16'h0000, 0, 0, 1, 6'd0, 1, 0, 0, 8'h00, 0, 0);
    add(16'hc7ee, 1, 1, 1, 6'd0,  1, 0, 1, 8'hee, 1, 1);
    add(16'h0000, 0, 1, 1, 6'd0,  1, 0, 0, 8'h00, 1, 0);
    add(16'hc7dd, 1, 0, 1, 6'd0,  1, 0, 1, 8'hdd, 2, 1);
    add(16'hffff, 1, 1, 1, P_FF,  0, 0, 0, 8'h00, 2, 0);
    add(16'h0000, 0, 0, 1, 6'd0,  0, 0, 0, 8'h00, 2, 0);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_pulses", pls, 6'd0);
    chk("rst_active", audio_active, 0);
    chk("rst_rate44", audio_rate_44k, 0);
    chk("rst_svalid", sample_valid, 0);
    chk("rst_sdata", sample_data, 0);
    chk("rst_count", sample_count, 0);
    chk("rst_op_ready", op_ready, 1);

    for (int i = 0; i < tbl.size(); i++) run(i, tbl[i]);

    // Reset while a sample sits in the buffer discards it.
    op = 16'h1f00;
    op_valid = 1'b1;
    sample_ready = 1'b0;
    @(posedge clk);
    #1;
    op = 16'hc7ab;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    chk("mid_svalid_pre", sample_valid, 1);
    chk("mid_sdata_pre", sample_data, 8'hab);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_svalid", sample_valid, 0);
    chk("mid_active", audio_active, 0);
    chk("mid_count", sample_count, 0);
    chk("mid_sdata", sample_data, 0);
    sample_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_svalid_post", sample_valid, 0);
    chk("sb_left", sb.size(), 0);
`ifdef OPDISP_ERR_STATS_EN
    chk("err_sticky_reset", err_sticky, 0);
    chk("unk_count_reset", unknown_op_count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/op_dispatcher.md
Name: op_dispatcher

Overview:
- Registered, flow-controlled successor to the combinational op decoder.
- Accepts 16-bit packets from the monitor-link deserializer and decodes them into one-cycle command pulses.
- Tracks audio stream state (22 kHz / 44 kHz) with an idle timeout.
- Forwards audio sample payloads through a one-entry output buffer with valid/ready backpressure toward the audio DMA path.

Parameters:
- OP_WIDTH, 16: packet width; command byte is op[OP_WIDTH-1 -: 8], payload is op[OP_WIDTH-9:0].
- SAMPLE_W, OP_WIDTH-8: width of sample_data.
- CNT_W, 16: width of sample_count (saturating).
- TIMEOUT, 4096: idle cycles in a RUN state before automatic return to IDLE; 0 disables timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op  in  OP_WIDTH  packet
- op_valid  in  1  packet present
- op_ready  out  1  packet accepted when op_valid && op_ready
- power_on_r1  out  1  one-cycle pulse, op == 16'hc5ef
- kbd_led_update  out  1  one-cycle pulse, op == 16'hc500
- all_1_packet  out  1  one-cycle pulse, cmd byte 8'hff
- audio_start  out  1  one-cycle pulse, cmd byte 8'h1f or 8'h0f
- audio_active  out  1  state is RUN22 or RUN44
- audio_rate_44k  out  1  1 in RUN44, else 0
- sample_data  out  SAMPLE_W  buffered payload
- sample_valid  out  1  buffer full
- sample_ready  in  1  consumer accepts when sample_valid && sample_ready
- sample_count  out  CNT_W  samples forwarded since last start, saturating at all-ones
- orphan_sample  out  1  one-cycle pulse: 8'hc7 packet received in IDLE (discarded)
- stream_timeout  out  1  one-cycle pulse on timeout exit

Behaviour:
- Reset: all outputs 0, state IDLE, buffer empty, counters 0. A reset mid-stream discards the buffered sample.
- op_ready = !sample_valid || sample_ready. It is combinational from the buffer state and sample_ready, for all packet types, so command order is preserved.
- Decode priority, exact matches first:
  - c5ef
  - c500
  - cmd ff
  - cmd 1f
  - cmd 0f
  - cmd c7
  - all others ignored (accepted, no effect)
- Latency: a packet accepted in cycle N produces its pulse or state change at N+1. A sample becomes sample_valid at N+1.
- State machine: IDLE, RUN22, RUN44.
  - Any state + cmd 1f -> RUN22. Any state + cmd 0f -> RUN44. Both pulse audio_start and clear sample_count and the timeout counter.
  - A start packet received while running restarts the stream but keeps any already-buffered sample.
  - cmd ff in any state -> IDLE. It also flushes the sample buffer (sample_valid=0 next cycle, even if sample_ready is low) and pulses all_1_packet.
  - cmd c7 in RUN22/RUN44: payload loaded into the buffer, sample_count += 1 (saturating), timeout counter cleared.
  - cmd c7 in IDLE: dropped, orphan_sample pulses, buffer untouched.
- Buffer:
  - Load and drain in the same cycle is allowed: new data replaces old, sample_valid stays 1.
  - sample_data is held stable while sample_valid && !sample_ready.
- Timeout:
  - In RUN22/RUN44 the counter increments on every cycle without an accepted c7 packet.
  - On reaching TIMEOUT-1: state -> IDLE and stream_timeout pulses. The buffered sample is retained and still delivered.
  - An accepted c7 and a timeout in the same cycle: the sample wins, the counter clears, no timeout.
- Non-audio pulses are unaffected by state.

Optional Feature:
- Macro OPDISP_ERR_STATS_EN.
- When defined, the block adds two outputs:
  - unknown_op_count (16 bits, saturating): increments per accepted packet that matches no rule.
  - err_sticky (1 bit): set on orphan_sample, stream_timeout, or unknown op; cleared only by reset.
- When undefined, neither port exists and no related logic is synthesised.

Test Plan:
- Reset, then op=c5ef valid 1 cycle -> power_on_r1=1 exactly one cycle later, all other outputs 0.
- op=1f00, then three c7 packets c712/c734/c756 with sample_ready=1 -> audio_active=1, audio_rate_44k=0; sample_data sequence 12,34,56; sample_count=3.
- RUN44 (0f00), sample_ready=0, send c7aa then c7bb -> op_ready=0 after the first packet; sample_data holds aa. Raise sample_ready -> aa consumed, then bb delivered; no loss or reorder.
- RUN22 with buffered sample and sample_ready=0, send ffff (op_ready must first go high, so raise sample_ready for that cycle only) -> all_1_packet pulse, state IDLE, sample_valid=0 the next cycle.
- IDLE, send c7ff -> orphan_sample pulse, sample_valid stays 0, sample_count unchanged.
- TIMEOUT=8, op=0f00, then no packets -> stream_timeout pulses 8 cycles after the start takes effect, audio_active=0. Repeat with c7 arriving on the terminal cycle -> no timeout.
